// File: rtl/byte_pack_pkg.sv
// Shared widths, types and lane mapping for the byte-to-word packer.
// Endianness selected by BYTE_PACK_SWAP_EN (defined: big-endian, undefined: little-endian).
package byte_pack_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned LANE_W         = 5;
    localparam int unsigned NBYTES_W       = 3;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [LANE_W-1:0] lane_t;

    localparam idx_t IDX_LAST = idx_t'(BYTES_PER_WORD - 1);

    // Bit position of the least significant bit of byte lane idx.
    function automatic lane_t lane_lsb(input idx_t idx);
`ifdef BYTE_PACK_SWAP_EN
        lane_lsb = lane_t'(WORD_W - BYTE_W) - lane_t'({idx, 3'b000});
`else
        lane_lsb = lane_t'({idx, 3'b000});
`endif
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into 32-bit words, with early flush on in_last.
// Build option BYTE_PACK_SWAP_EN selects big-endian lane order.
module byte_word_packer
    import byte_pack_pkg::*;
#(
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   in_byte,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [WORD_W-1:0]   out_word,
    output logic [NBYTES_W-1:0] out_bytes,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    word_count
);

    localparam logic [WORD_W-1:0] PAD_WORD = {BYTES_PER_WORD{PAD_BYTE}};

    logic [WORD_W-1:0]   acc, acc_nxt;
    idx_t                idx, idx_nxt;
    logic [WORD_W-1:0]   word_nxt;
    logic [NBYTES_W-1:0] bytes_nxt;
    logic                valid_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic [WORD_W-1:0]   merged;
    logic                in_xfer;
    logic                out_xfer;
    logic                emit;

    // Write byte b into lane at; lanes not yet filled read as PAD_BYTE.
    function automatic logic [WORD_W-1:0] merge_word(
        input logic [WORD_W-1:0] acc_v,
        input idx_t              at,
        input logic [BYTE_W-1:0] b
    );
        logic [WORD_W-1:0] w;
        w = acc_v;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (idx_t'(k) == at) begin
                w[lane_lsb(idx_t'(k)) +: BYTE_W] = b;
            end else if (idx_t'(k) > at) begin
                w[lane_lsb(idx_t'(k)) +: BYTE_W] = PAD_BYTE;
            end
        end
        return w;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign emit     = in_xfer && ((idx == IDX_LAST) || in_last);
    assign merged   = merge_word(acc, idx, in_byte);

    // Next-state: an emit overrides a same-cycle drain so the output never bubbles.
    always_comb begin
        acc_nxt   = acc;
        idx_nxt   = idx;
        word_nxt  = out_word;
        bytes_nxt = out_bytes;
        valid_nxt = out_valid;
        count_nxt = word_count;

        if (out_xfer) begin
            valid_nxt = 1'b0;
        end

        if (emit) begin
            word_nxt  = merged;
            bytes_nxt = NBYTES_W'(idx) + NBYTES_W'(1);
            valid_nxt = 1'b1;
            idx_nxt   = '0;
            acc_nxt   = PAD_WORD;
            count_nxt = word_count + CNT_W'(1);
        end else if (in_xfer) begin
            acc_nxt = merged;
            idx_nxt = idx + idx_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            idx        <= '0;
            out_word   <= '0;
            out_bytes  <= '0;
            out_valid  <= 1'b0;
            word_count <= '0;
        end else begin
            acc        <= acc_nxt;
            idx        <= idx_nxt;
            out_word   <= word_nxt;
            out_bytes  <= bytes_nxt;
            out_valid  <= valid_nxt;
            word_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Randomized bench for byte_word_packer against a packet-level reference model.
// Honors BYTE_PACK_SWAP_EN for expected lane order.
module tb_byte_word_packer;
    import byte_pack_pkg::*;

    localparam logic [7:0]  TB_PAD   = 8'hFF;
    localparam int unsigned TB_CNT_W = 4;
    localparam int unsigned CNT_MOD  = 1 << TB_CNT_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          in_byte;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [31:0]         out_word;
    logic [2:0]          out_bytes;
    logic                out_valid;
    logic                out_ready;
    logic [TB_CNT_W-1:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          mv;
    logic [31:0] mword;
    logic [2:0]  mbytes;
    int unsigned mcount;
    logic [7:0]  pkt[$];
    logic [31:0] held;

    byte_word_packer #(.PAD_BYTE(TB_PAD), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_word(out_word),
        .out_bytes(out_bytes), .out_valid(out_valid), .out_ready(out_ready),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_pkt();
        logic [31:0] w;
        logic [7:0]  lane;
        w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            lane = (i < pkt.size()) ? pkt[i] : TB_PAD;
`ifdef BYTE_PACK_SWAP_EN
            w = w | ({24'd0, lane} << (8 * (3 - i)));
`else
            w = w | ({24'd0, lane} << (8 * i));
`endif
        end
        return w;
    endfunction

    function automatic logic [31:0] le_or_be(input logic [31:0] le, input logic [31:0] be);
`ifdef BYTE_PACK_SWAP_EN
        return be;
`else
        return le;
`endif
    endfunction

    task automatic model_reset();
        mv = 1'b0; mword = '0; mbytes = '0; mcount = 0;
        pkt.delete();
    endtask

    // Apply inputs just after an edge, check in_ready, advance the model.
    task automatic drive(input bit v, input logic [7:0] b, input bit l, input bit r);
        bit ixfer, oxfer;
        in_valid = v; in_byte = b; in_last = l; out_ready = r;
        #1;
        check("in_ready", 32'(in_ready), 32'(!mv || r));
        ixfer = v && (!mv || r);
        oxfer = mv && r;
        if (oxfer) mv = 1'b0;
        if (ixfer) begin
            pkt.push_back(b);
            if (pkt.size() == 4 || l) begin
                mword  = pack_pkt();
                mbytes = 3'(pkt.size());
                mv     = 1'b1;
                mcount = (mcount + 1) % CNT_MOD;
                pkt.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(mv));
        check("out_word", out_word, mword);
        check("out_bytes", 32'(out_bytes), 32'(mbytes));
        check("word_count", 32'(word_count), mcount);
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit l, input bit r);
        drive(v, b, l, r);
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_bytes", 32'(out_bytes), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // Single full word
        step(1, 8'h63, 0, 1); step(1, 8'h56, 0, 1); step(1, 8'hF0, 0, 1);
        check("tp1_pre_valid", 32'(out_valid), 32'd0);
        step(1, 8'hB1, 0, 1);
        check("tp1_word", out_word, le_or_be(32'hB1F05663, 32'h6356F0B1));
        check("tp1_bytes", 32'(out_bytes), 32'd4);
        check("tp1_count", 32'(word_count), 32'd1);

        // Back-to-back words at full rate
        step(1, 8'h81, 0, 1); step(1, 8'h5E, 0, 1); step(1, 8'h89, 0, 1); step(1, 8'hC0, 0, 1);
        check("tp2_word0", out_word, le_or_be(32'hC0895E81, 32'h815E89C0));
        step(1, 8'h8D, 0, 1); step(1, 8'h99, 0, 1); step(1, 8'hDF, 0, 1); step(1, 8'h46, 0, 1);
        check("tp2_word1", out_word, le_or_be(32'h46DF998D, 32'h8D99DF46));
        check("tp2_count", 32'(word_count), 32'd3);

        // Partial flush with padding
        step(1, 8'h09, 0, 1); step(1, 8'hD6, 1, 1);
        check("tp3_word", out_word, le_or_be(32'hFFFFD609, 32'h09D6FFFF));
        check("tp3_bytes", 32'(out_bytes), 32'd2);

        // Stall: word held, input blocked
        held = out_word;
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h77, 0, 0);
            check("tp4_in_ready", 32'(in_ready), 32'd0);
            check("tp4_hold", out_word, held);
        end
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
        check("tp4_word", out_word, le_or_be(32'h44332211, 32'h11223344));

        // Asynchronous reset mid-word
        step(1, 8'hAA, 0, 1); step(1, 8'hBB, 0, 1);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("tp5_valid", 32'(out_valid), 32'd0);
        check("tp5_word", out_word, 32'd0);
        check("tp5_bytes", 32'(out_bytes), 32'd0);
        check("tp5_count", 32'(word_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
        check("tp5_next_word", out_word, le_or_be(32'h04030201, 32'h01020304));
        check("tp5_next_count", 32'(word_count), 32'd1);

        // Counter wrap
        for (int w = 0; w < 20 && mcount != CNT_MOD - 1; w++) begin
            for (int k = 0; k < 4; k++) step(1, 8'($urandom), 0, 1);
        end
        check("tp6_at_max", 32'(word_count), CNT_MOD - 1);
        for (int k = 0; k < 4; k++) step(1, 8'($urandom), 0, 1);
        check("tp6_wrap", 32'(word_count), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
